// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-pipeline widths, MSHR depth and the replay entry layout.
package mem_pkg;
   localparam int MEM_NUM_WARPS = 8;
   localparam int MEM_WARP_W    = 3;
   localparam int MEM_SCB_W     = 2;
   localparam int MEM_ADDR_W    = 27;
   localparam int MSHR_DEPTH    = 8;
   localparam int MEM_RQ_DEPTH  = MSHR_DEPTH;
   localparam int MEM_CNT_W     = 4;

   typedef struct packed {
      logic [MEM_SCB_W-1:0]  scb_id;
      logic [MEM_WARP_W-1:0] warp_id;
      logic [MEM_ADDR_W-1:0] addr;
   } replay_entry_t;
endpackage

// File: rtl/replay_fifo.sv
// replay_fifo: circular replay queue with a registered one-entry output stage and bypass.
// MISS_REPLAY_STATS_EN adds the occ_o occupancy output (queue plus output register).
module replay_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetb,
`ifdef MISS_REPLAY_STATS_EN
   output logic [$clog2(DEPTH):0]   occ_o,
`endif
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic [W-1:0]             data_o,
   output logic                     drop_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  wp_q, rp_q;
   logic [W-1:0] mem [DEPTH];
   logic         empty, full, out_free, q_pop, q_push, bypass;

   assign empty    = wp_q == rp_q;
   assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign out_free = !valid_o || ready_i;
   assign q_pop    = out_free && !empty;
   assign bypass   = push_i && empty && out_free;
   // A full queue still accepts when its head moves to the output register this cycle.
   assign q_push   = push_i && !bypass && (!full || q_pop);
   assign drop_o   = push_i && full && !q_pop;
`ifdef MISS_REPLAY_STATS_EN
   assign occ_o    = (wp_q - rp_q) + (AW+1)'(valid_o);
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wp_q    <= '0;
         rp_q    <= '0;
         valid_o <= 1'b0;
      end else begin
         wp_q    <= wp_q + (AW+1)'(q_push);
         rp_q    <= rp_q + (AW+1)'(q_pop);
         valid_o <= out_free ? (!empty || push_i) : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (q_push) mem[wp_q[AW-1:0]] <= push_data_i;
      if (q_pop) data_o <= mem[rp_q[AW-1:0]];
      else if (bypass) data_o <= push_data_i;
   end
endmodule

// File: rtl/miss_replay_ctrl.sv
// miss_replay_ctrl: MSHR miss-feedback consumer; replays completions to the LSU and stalls warps with pending misses.
// MISS_REPLAY_STATS_EN adds stat_replays and stat_max_occ outputs.
module miss_replay_ctrl
   import mem_pkg::*;
#(
   parameter int NUM_WARPS = MEM_NUM_WARPS,
   parameter int WARP_W    = MEM_WARP_W,
   parameter int SCB_W     = MEM_SCB_W,
   parameter int ADDR_W    = MEM_ADDR_W,
   parameter int RQ_DEPTH  = MEM_RQ_DEPTH,
   parameter int CNT_W     = MEM_CNT_W
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  miss_valid,
   input  logic [WARP_W-1:0]     miss_warpID,
   input  logic                  fb_valid,
   input  logic [SCB_W-1:0]      fb_scbID,
   input  logic [WARP_W-1:0]     fb_warpID,
   input  logic [ADDR_W-1:0]     fb_addr,
   output logic                  replay_valid,
   input  logic                  replay_ready,
   output logic [SCB_W-1:0]      replay_scbID,
   output logic [WARP_W-1:0]     replay_warpID,
   output logic [ADDR_W-1:0]     replay_addr,
   output logic [NUM_WARPS-1:0]  warp_stall_mask,
   output logic                  err_overflow
`ifdef MISS_REPLAY_STATS_EN
   ,
   output logic [15:0]               stat_replays,
   output logic [$clog2(RQ_DEPTH):0] stat_max_occ
`endif
);
   localparam int E_W = SCB_W + WARP_W + ADDR_W;
   localparam int AW  = $clog2(RQ_DEPTH);
   logic                 xfer, drop;
   logic [E_W-1:0]       rdata;
   logic [CNT_W-1:0]     cnt_q [NUM_WARPS];
   logic [CNT_W-1:0]     cnt_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] nz_d, cnt_err;

   assign xfer = replay_valid && replay_ready;
   assign {replay_scbID, replay_warpID, replay_addr} = rdata;

`ifdef MISS_REPLAY_STATS_EN
   logic [AW:0] occ;
`endif

   replay_fifo #(.W(E_W), .DEPTH(RQ_DEPTH)) u_fifo (
      .clk         (clk),
      .resetb      (resetb),
`ifdef MISS_REPLAY_STATS_EN
      .occ_o       (occ),
`endif
      .push_i      (fb_valid),
      .push_data_i ({fb_scbID, fb_warpID, fb_addr}),
      .ready_i     (replay_ready),
      .valid_o     (replay_valid),
      .data_o      (rdata),
      .drop_o      (drop)
   );

   genvar w;
   for (w = 0; w < NUM_WARPS; w++) begin : g_cnt
      logic inc, dec;
      assign inc        = miss_valid && (miss_warpID == WARP_W'(w));
      assign dec        = xfer && (replay_warpID == WARP_W'(w));
      assign cnt_d[w]   = (inc && !dec && !(&cnt_q[w])) ? cnt_q[w] + CNT_W'(1) :
                          (dec && !inc && cnt_q[w] != '0) ? cnt_q[w] - CNT_W'(1) : cnt_q[w];
      assign cnt_err[w] = (inc && !dec && (&cnt_q[w])) || (dec && !inc && cnt_q[w] == '0);
      assign nz_d[w]    = cnt_d[w] != '0;
      always_ff @(posedge clk or negedge resetb) begin
         if (!resetb) cnt_q[w] <= '0;
         else cnt_q[w] <= cnt_d[w];
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         warp_stall_mask <= '0;
         err_overflow    <= 1'b0;
      end else begin
         warp_stall_mask <= nz_d;
         err_overflow    <= err_overflow || drop || (|cnt_err);
      end
   end

`ifdef MISS_REPLAY_STATS_EN
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         stat_replays <= '0;
         stat_max_occ <= '0;
      end else begin
         stat_replays <= stat_replays + 16'(xfer);
         if (occ > stat_max_occ) stat_max_occ <= occ;
      end
   end
`endif
endmodule

// File: doc/miss_replay_ctrl.md
Name: miss_replay_ctrl

Overview:
- Consumer end of the MSHR negative-feedback interface.
- Tracks outstanding cache misses per warp and accepts miss-completion feedback pulses, which cannot be back-pressured.
- Buffers completions in a replay queue and re-injects them into the LSU with a valid/ready handshake.
- Drives a per-warp stall mask to the warp scheduler so a warp with unreplayed misses is not issued further memory ops.

Parameters:
- NUM_WARPS, 8, number of warps; one counter and one mask bit per warp.
- WARP_W, 3, warp ID width.
- SCB_W, 2, scoreboard ID width.
- ADDR_W, 27, cache-line address width.
- RQ_DEPTH, 8, replay queue entries; power of 2, equal to the MSHR depth.
- CNT_W, 4, per-warp outstanding counter width.

Ports:
- clk  in  1  clock.
- resetb  in  1  asynchronous active-low reset.
- miss_valid  in  1  miss allocated into MSHR this cycle (hit_missbar low, addr valid, MSHR not full).
- miss_warpID  in  WARP_W  warp owning the allocated miss.
- fb_valid  in  1  miss-completion pulse from MSHR; no ready, must be taken.
- fb_scbID  in  SCB_W  scoreboard ID of the completing miss.
- fb_warpID  in  WARP_W  warp ID of the completing miss.
- fb_addr  in  ADDR_W  line address of the completing miss.
- replay_valid  out  1  replay request to LSU.
- replay_ready  in  1  LSU accepts the replay.
- replay_scbID  out  SCB_W  replay scoreboard ID.
- replay_warpID  out  WARP_W  replay warp ID.
- replay_addr  out  ADDR_W  replay line address.
- warp_stall_mask  out  NUM_WARPS  bit w = 1 while warp w has outstanding or unreplayed misses.
- err_overflow  out  1  sticky; feedback dropped (queue full) or counter saturation/underflow.

Behaviour:
- Reset (async, resetb low):
  - All counters, queue pointers, replay_valid, warp_stall_mask and err_overflow go to 0.
  - Queue payload is not reset.
  - Reset may assert mid-operation. All in-flight state is discarded, and no replay_valid glitch is permitted on reset release.
- Replay queue:
  - Circular FIFO with WARP_W-independent pointers, log2(RQ_DEPTH)+1 bits each (extra wrap bit).
  - empty = pointers equal; full = MSB differs and the index bits are equal.
- Push: on fb_valid, the entry {scbID, warpID, addr} is written at the write pointer, which then increments.
- Output stage is registered:
  - replay_* come from a one-entry output register loaded from the queue head.
  - Feedback arriving when queue and output register are both empty loads the output register directly. replay_valid asserts the cycle after fb_valid (latency 1).
- Handshake:
  - Transfer occurs when replay_valid && replay_ready.
  - While replay_valid is high and ready is low, replay_* hold stable.
  - On transfer, the next head (if any) loads the same cycle edge, giving back-to-back replays at one per cycle.
- Simultaneous push and pop:
  - When full, push and pop in the same cycle is allowed and occupancy is unchanged.
  - When empty with the output register draining, push goes straight to the output register.
- Overflow: fb_valid with queue full and the output register full and not draining means the entry is dropped and err_overflow sets. It clears only on reset.
- Counters (pend_cnt[w], CNT_W bits):
  - Increment on miss_valid for miss_warpID.
  - Decrement on replay transfer for replay_warpID.
  - Same-warp increment and decrement in one cycle leave the count unchanged.
  - Increment at all-ones holds the count and sets err_overflow.
  - Decrement at 0 holds the count and sets err_overflow.
- warp_stall_mask[w] is registered and equals (next pend_cnt[w] != 0). It deasserts in the cycle after the last replay transfer for warp w.
- fb_warpID/fb_addr are not checked against counters; the counter reflects issued minus replayed.

Optional Feature:
- Macro: MISS_REPLAY_STATS_EN.
- Defined:
  - Adds outputs stat_replays (16 bit, wrapping count of replay transfers) and stat_max_occ (log2(RQ_DEPTH)+1 bit, high-water mark of queue plus output register occupancy).
  - Both reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - warp/scb/addr width constants.
  - A replay entry struct/typedef {scbID, warpID, addr}.
  - Default RQ_DEPTH, tied to the MSHR depth constant.
- One natural sub-module: replay_fifo (pointers, storage, full/empty, output register).
- Counters and mask stay in the top module.

Test Plan:
- Single miss/replay:
  - miss_valid warp 3 -> stall_mask=0x08 next cycle.
  - fb_valid {scb 2, warp 3, addr 0x1ABCDEF} at cycle N -> replay_valid at N+1 with the same fields.
  - ready=1 -> mask returns to 0x00 at N+2.
- Back-pressure: 3 feedbacks on consecutive cycles with ready=0 for 5 cycles -> replay_* stable on entry 0. Ready high -> 3 transfers on 3 consecutive cycles in FIFO order.
- Full/wrap:
  - 9 feedbacks with ready=0 -> queue full plus output register holding 9 entries; 10th feedback -> err_overflow=1 and the entry is lost.
  - Drain across pointer wrap -> order is preserved.
- Simultaneous events:
  - miss_valid warp 5 and replay transfer warp 5 in the same cycle with cnt=1 -> cnt stays 1, mask bit 5 stays 1.
  - Push and pop while full -> occupancy unchanged.
- Async reset mid-stream: assert resetb=0 between clock edges with 4 entries queued -> replay_valid, mask and err drop immediately. After release, no spurious replay occurs.
- Counter saturation: 16 misses on warp 0 with no replays -> cnt holds 15 and err_overflow=1. A decrement at 0 on another warp is also flagged.
